wb_return_buf: RTL and testbench
================================

# wb_return_buf

Writeback return buffer at the MEM end of the pipeline: accepts completed MEM-stage results and carries them back to the ID-stage register-file write port. It is the return counterpart of the forward ID→MEM pipeline register: two-entry skid storage with valid/ready handshaking on both sides. It absorbs register-file write-port stalls without dropping results, supports pipeline flush, and optionally bypasses pending results to ID operand reads.

## Interface
- DATA_W, default `WIDTH (params.v): data/instruction width
- REG_AW, default 5: register index width
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  MEM result valid
- in_ready  out  1  buffer can accept
- ir_in  in  DATA_W  instruction word
- pc_in  in  DATA_W-2  instruction PC
- res_in  in  DATA_W  result data
- rd_in  in  REG_AW  destination register
- we_in  in  1  result writes register file
- flush  in  1  discard all buffered entries
- wb_valid  out  1  head entry presented to register file
- wb_ready  in  1  register file accepts head
- wb_ir / wb_pc / wb_data / wb_rd / wb_we  out  DATA_W / DATA_W-2 / DATA_W / REG_AW / 1  head entry fields
- occupancy  out  2  entries held (0..2)
- fwd_rs1, fwd_rs2  in  REG_AW  ID source indices (WB_FWD_EN only)
- fwd_hit1, fwd_hit2  out  1  match found (WB_FWD_EN only)
- fwd_data1, fwd_data2  out  DATA_W  bypass data (WB_FWD_EN only)

## Operation
- States: EMPTY, ONE, TWO; occupancy = 0/1/2.
- Push = in_valid & in_ready. Pop = wb_valid & wb_ready.
- in_ready = (state != TWO); it is derived from registered state only, with no combinational path from wb_ready.
- wb_valid = (state != EMPTY). Head fields come straight from the head register.
- Transitions:
  - EMPTY: push→ONE.
  - ONE: push only→TWO; pop only→EMPTY; push and pop→ONE, new entry becomes head.
  - TWO: pop→ONE, second entry moves to head. A push cannot occur in TWO.
- Order is strict FIFO. Entries are never reordered or duplicated.
- flush: next state EMPTY regardless of push or pop in the same cycle. The simultaneous push is dropped. A pop in the flush cycle still counts as accepted by the register file.
- Entries with we_in=0 are still buffered and popped; they carry the PC/IR trace.
- Reset: state EMPTY, all stored fields and all outputs 0, in_ready=1.

## Timing
- Latency: push at edge N gives wb_valid=1 with that entry's data after edge N.
- Full throughput: one push and one pop per cycle sustained in ONE.
- Head fields stay stable while wb_valid=1 and wb_ready=0.
- Forwarding outputs are combinational from stored entries and fwd_rs*. They reflect state after the last edge and never reflect in-flight inputs.

## Configuration
- WB_FWD_EN defined: fwd_* ports exist.
  - fwd_hitK=1 when a valid entry has we=1, rd==fwd_rsK and rd!=0.
  - When both entries match, the newest (tail) entry wins for fwd_dataK.
  - fwd_dataK=0 on miss.
- WB_FWD_EN undefined: fwd_* ports and compare logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package/params.v: the WIDTH macro, and state encodings WRB_EMPTY=2'd0, WRB_ONE=2'd1, WRB_TWO=2'd2.
- One sub-module, wrb_entry: a single storage entry (ir, pc, data, rd, we) with load enable. It is instantiated twice as head and tail.

## Test plan
- Reset mid-traffic: assert rst while in state TWO → all outputs 0 immediately, occupancy=0, in_ready=1.
- Single push of res_in=32'hDEAD_BEEF, rd=3, wb_ready=1 → wb_valid for exactly 1 cycle with wb_data=32'hDEAD_BEEF, wb_rd=3.
- Stall: wb_ready=0, push A then B → occupancy=2, in_ready=0, head=A. Then wb_ready=1 → A popped, then B popped.
- Simultaneous push/pop in ONE with continuous stream 1,2,3,4 → occupancy stays 1 and output order is 1,2,3,4.
- Flush in state TWO with concurrent in_valid=1 → occupancy=0 next cycle and the concurrent input never appears on wb_*.
- WB_FWD_EN: entries rd=5/data=10 (older) and rd=5/data=20 (newer), fwd_rs1=5 → fwd_hit1=1, fwd_data1=20. fwd_rs2=0 with an entry having rd=0 → fwd_hit2=0.

Source files
------------

// File: rtl/wb_return_buf_pkg.sv
// rtl/wb_return_buf_pkg.sv - shared width and state encodings for the writeback return buffer
`ifndef WIDTH
`define WIDTH 32
`endif

package wb_return_buf_pkg;

    localparam int WRB_WIDTH  = `WIDTH;
    localparam int WRB_REG_AW = 5;

    typedef enum logic [1:0] {
        WRB_EMPTY = 2'd0,
        WRB_ONE   = 2'd1,
        WRB_TWO   = 2'd2
    } wrb_state_e;

endpackage

// File: rtl/wb_return_buf_if.sv
// rtl/wb_return_buf_if.sv - MEM-side result stream and register-file writeback handshake
interface wb_return_buf_if
    import wb_return_buf_pkg::*;
#(
    parameter int DATA_W = WRB_WIDTH,
    parameter int REG_AW = WRB_REG_AW
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ir_in;
    logic [DATA_W-3:0] pc_in;
    logic [DATA_W-1:0] res_in;
    logic [REG_AW-1:0] rd_in;
    logic              we_in;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_ir;
    logic [DATA_W-3:0] wb_pc;
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_we;

    modport master (
        output in_valid, ir_in, pc_in, res_in, rd_in, we_in, wb_ready,
        input  in_ready, wb_valid, wb_ir, wb_pc, wb_data, wb_rd, wb_we
    );

    modport slave (
        input  in_valid, ir_in, pc_in, res_in, rd_in, we_in, wb_ready,
        output in_ready, wb_valid, wb_ir, wb_pc, wb_data, wb_rd, wb_we
    );
endinterface

// File: rtl/wb_return_buf_entry.sv
// rtl/wb_return_buf_entry.sv - wrb_entry: one buffered result (ir, pc, data, rd, we) with load enable
module wrb_entry
    import wb_return_buf_pkg::*;
#(
    parameter int DATA_W = WRB_WIDTH,
    parameter int REG_AW = WRB_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_ir,
    input  logic [DATA_W-3:0] i_pc,
    input  logic [DATA_W-1:0] i_data,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_we,
    output logic [DATA_W-1:0] o_ir,
    output logic [DATA_W-3:0] o_pc,
    output logic [DATA_W-1:0] o_data,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_we
);
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-3:0] r_pc;
    logic [DATA_W-1:0] r_data;
    logic [REG_AW-1:0] r_rd;
    logic              r_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir   <= '0;
            r_pc   <= '0;
            r_data <= '0;
            r_rd   <= '0;
            r_we   <= 1'b0;
        end else if (i_load) begin
            r_ir   <= i_ir;
            r_pc   <= i_pc;
            r_data <= i_data;
            r_rd   <= i_rd;
            r_we   <= i_we;
        end
    end

    assign o_ir   = r_ir;
    assign o_pc   = r_pc;
    assign o_data = r_data;
    assign o_rd   = r_rd;
    assign o_we   = r_we;
endmodule

// File: rtl/wb_return_buf.sv
// rtl/wb_return_buf.sv - two-entry MEM->ID writeback skid buffer; WB_FWD_EN adds operand bypass
module wb_return_buf
    import wb_return_buf_pkg::*;
#(
    parameter int DATA_W = WRB_WIDTH,
    parameter int REG_AW = WRB_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    wb_return_buf_if.slave    bus,
    input  logic              flush,
    output logic [1:0]        occupancy
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0] fwd_rs1,
    input  logic [REG_AW-1:0] fwd_rs2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);
    wrb_state_e        r_state;
    wrb_state_e        w_next_state;
    logic              w_push;
    logic              w_pop;
    logic              w_load_head;
    logic              w_load_tail;
    logic              w_head_from_tail;

    logic [DATA_W-1:0] w_head_ir_d;
    logic [DATA_W-3:0] w_head_pc_d;
    logic [DATA_W-1:0] w_head_data_d;
    logic [REG_AW-1:0] w_head_rd_d;
    logic              w_head_we_d;

    logic [DATA_W-1:0] w_head_ir;
    logic [DATA_W-3:0] w_head_pc;
    logic [DATA_W-1:0] w_head_data;
    logic [REG_AW-1:0] w_head_rd;
    logic              w_head_we;

    logic [DATA_W-1:0] w_tail_ir;
    logic [DATA_W-3:0] w_tail_pc;
    logic [DATA_W-1:0] w_tail_data;
    logic [REG_AW-1:0] w_tail_rd;
    logic              w_tail_we;

    // Handshake outputs depend on registered state only, so wb_ready never reaches in_ready.
    assign bus.in_ready = (r_state != WRB_TWO);
    assign bus.wb_valid = (r_state != WRB_EMPTY);
    assign occupancy    = r_state;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.wb_valid & bus.wb_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WRB_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_head      = 1'b0;
        w_load_tail      = 1'b0;
        w_head_from_tail = 1'b0;
        case (r_state)
            WRB_EMPTY: begin
                if (w_push) begin
                    w_next_state = WRB_ONE;
                    w_load_head  = 1'b1;
                end
            end
            WRB_ONE: begin
                if (w_push && w_pop) begin
                    w_load_head  = 1'b1;
                end else if (w_push) begin
                    w_next_state = WRB_TWO;
                    w_load_tail  = 1'b1;
                end else if (w_pop) begin
                    w_next_state = WRB_EMPTY;
                end
            end
            WRB_TWO: begin
                if (w_pop) begin
                    w_next_state     = WRB_ONE;
                    w_load_head      = 1'b1;
                    w_head_from_tail = 1'b1;
                end
            end
            default: begin
                w_next_state = WRB_EMPTY;
            end
        endcase
        // Flush wins over everything; the concurrent push never lands in storage.
        if (flush) begin
            w_next_state     = WRB_EMPTY;
            w_load_head      = 1'b0;
            w_load_tail      = 1'b0;
            w_head_from_tail = 1'b0;
        end
    end

    assign w_head_ir_d   = w_head_from_tail ? w_tail_ir   : bus.ir_in;
    assign w_head_pc_d   = w_head_from_tail ? w_tail_pc   : bus.pc_in;
    assign w_head_data_d = w_head_from_tail ? w_tail_data : bus.res_in;
    assign w_head_rd_d   = w_head_from_tail ? w_tail_rd   : bus.rd_in;
    assign w_head_we_d   = w_head_from_tail ? w_tail_we   : bus.we_in;

    wrb_entry #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_head (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_head),
        .i_ir   (w_head_ir_d),
        .i_pc   (w_head_pc_d),
        .i_data (w_head_data_d),
        .i_rd   (w_head_rd_d),
        .i_we   (w_head_we_d),
        .o_ir   (w_head_ir),
        .o_pc   (w_head_pc),
        .o_data (w_head_data),
        .o_rd   (w_head_rd),
        .o_we   (w_head_we)
    );

    wrb_entry #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_tail (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_tail),
        .i_ir   (bus.ir_in),
        .i_pc   (bus.pc_in),
        .i_data (bus.res_in),
        .i_rd   (bus.rd_in),
        .i_we   (bus.we_in),
        .o_ir   (w_tail_ir),
        .o_pc   (w_tail_pc),
        .o_data (w_tail_data),
        .o_rd   (w_tail_rd),
        .o_we   (w_tail_we)
    );

    assign bus.wb_ir   = w_head_ir;
    assign bus.wb_pc   = w_head_pc;
    assign bus.wb_data = w_head_data;
    assign bus.wb_rd   = w_head_rd;
    assign bus.wb_we   = w_head_we;

`ifdef WB_FWD_EN
    logic w_head_live;
    logic w_tail_live;
    logic w_h1, w_t1, w_h2, w_t2;

    assign w_head_live = (r_state != WRB_EMPTY) && w_head_we && (w_head_rd != '0);
    assign w_tail_live = (r_state == WRB_TWO)   && w_tail_we && (w_tail_rd != '0);

    assign w_h1 = w_head_live && (w_head_rd == fwd_rs1);
    assign w_t1 = w_tail_live && (w_tail_rd == fwd_rs1);
    assign w_h2 = w_head_live && (w_head_rd == fwd_rs2);
    assign w_t2 = w_tail_live && (w_tail_rd == fwd_rs2);

    // Tail is the younger result, so it shadows the head on a double match.
    assign fwd_hit1  = w_h1 | w_t1;
    assign fwd_hit2  = w_h2 | w_t2;
    assign fwd_data1 = w_t1 ? w_tail_data : (w_h1 ? w_head_data : '0);
    assign fwd_data2 = w_t2 ? w_tail_data : (w_h2 ? w_head_data : '0);
`endif
endmodule

// File: tb/tb_wb_return_buf.sv
// tb/tb_wb_return_buf.sv - queue-model checked bench for wb_return_buf (optional WB_FWD_EN checks)
module tb_wb_return_buf;
    import wb_return_buf_pkg::*;

    typedef struct {
        logic [31:0] ir;
        logic [29:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [1:0] occupancy;
    int checks = 0;
    int errors = 0;
    ent_t q[$];
    logic [31:0] plog[$];

    wb_return_buf_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs1 = '0;
    logic [4:0]  fwd_rs2 = '0;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    wb_return_buf #(.DATA_W(32), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef WB_FWD_EN
        ,
        .fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void fwd_model(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (q[i]) begin
            if (q[i].we && q[i].rd == rs && rs != 5'd0) begin
                hit = 1'b1;
                d   = q[i].data;
            end
        end
    endfunction

    // Reference model: a plain FIFO of at most two results.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            automatic bit   push = bus.in_valid && (q.size() < 2);
            automatic bit   pop  = (q.size() != 0) && bus.wb_ready;
            automatic ent_t e;
            e.ir = bus.ir_in; e.pc = bus.pc_in; e.data = bus.res_in;
            e.rd = bus.rd_in; e.we = bus.we_in;
            if (pop) plog.push_back(q[0].data);
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("wb_valid", bus.wb_valid, q.size() != 0);
            chk("in_ready", bus.in_ready, q.size() < 2);
            chk("occupancy", occupancy, 64'(q.size()));
            if (q.size() != 0) begin
                chk("wb_data", bus.wb_data, q[0].data);
                chk("wb_ir", bus.wb_ir, q[0].ir);
                chk("wb_pc", bus.wb_pc, q[0].pc);
                chk("wb_rd", bus.wb_rd, q[0].rd);
                chk("wb_we", bus.wb_we, q[0].we);
            end
`ifdef WB_FWD_EN
            begin
                automatic logic h;
                automatic logic [31:0] d;
                fwd_model(fwd_rs1, h, d);
                chk("fwd_hit1", fwd_hit1, h);
                chk("fwd_data1", fwd_data1, d);
                fwd_model(fwd_rs2, h, d);
                chk("fwd_hit2", fwd_hit2, h);
                chk("fwd_data2", fwd_data2, d);
            end
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic wr);
        bus.in_valid = v;
        bus.res_in   = d;
        bus.ir_in    = ~d;
        bus.pc_in    = d[29:0] ^ 30'h155;
        bus.rd_in    = rd;
        bus.we_in    = 1'b1;
        bus.wb_ready = wr;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wb_valid"}, bus.wb_valid, 1'b0);
        chk({tag, "_wb_data"}, bus.wb_data, 32'h0);
        chk({tag, "_wb_ir"}, bus.wb_ir, 32'h0);
        chk({tag, "_wb_pc"}, bus.wb_pc, 30'h0);
        chk({tag, "_wb_rd"}, bus.wb_rd, 5'h0);
        chk({tag, "_wb_we"}, bus.wb_we, 1'b0);
        chk({tag, "_occ"}, occupancy, 2'd0);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        cyc();
        check_zero_outputs("reset");
        rst = 1'b0;
        cyc();

        // Single result with the register file ready: visible for exactly one cycle.
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1);
        cyc();
        chk("single_valid", bus.wb_valid, 1'b1);
        chk("single_data", bus.wb_data, 32'hDEAD_BEEF);
        chk("single_rd", bus.wb_rd, 5'd3);
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        cyc();
        chk("single_gone", bus.wb_valid, 1'b0);

        // Stall then drain: A then B.
        drive(1'b1, 32'hA, 5'd1, 1'b0);
        cyc();
        drive(1'b1, 32'hB, 5'd2, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        chk("stall_occ", occupancy, 2'd2);
        chk("stall_in_ready", bus.in_ready, 1'b0);
        chk("stall_head", bus.wb_data, 32'hA);
        cyc();
        chk("stall_hold", bus.wb_data, 32'hA);
        bus.wb_ready = 1'b1;
        cyc();
        chk("drain_head_b", bus.wb_data, 32'hB);
        chk("drain_occ1", occupancy, 2'd1);
        cyc();
        chk("drain_empty", occupancy, 2'd0);

        // Streaming 1..4 through state ONE.
        plog.delete();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 5'(i), 1'b1);
            cyc();
            chk("stream_occ", occupancy, 2'd1);
            chk("stream_head", bus.wb_data, 32'(i));
        end
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        cyc();
        chk("stream_count", 64'(plog.size()), 64'd4);
        for (int i = 0; i < 4 && i < plog.size(); i++)
            chk("stream_order", plog[i], 32'(i + 1));

        // Flush in TWO and in ONE, each with a concurrent input.
        plog.delete();
        drive(1'b1, 32'hC, 5'd4, 1'b0);
        cyc();
        drive(1'b1, 32'hD, 5'd4, 1'b0);
        cyc();
        drive(1'b1, 32'h55, 5'd6, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_two_occ", occupancy, 2'd0);
        chk("flush_two_valid", bus.wb_valid, 1'b0);
        drive(1'b1, 32'hE, 5'd7, 1'b0);
        cyc();
        drive(1'b1, 32'h66, 5'd7, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        chk("flush_one_occ", occupancy, 2'd0);
        for (int i = 0; i < 3; i++) cyc();
        begin
            automatic int leaked = 0;
            foreach (plog[i]) if (plog[i] == 32'h55 || plog[i] == 32'h66) leaked++;
            chk("flush_no_leak", 64'(leaked), 64'd0);
        end

`ifdef WB_FWD_EN
        drive(1'b1, 32'd10, 5'd5, 1'b0);
        cyc();
        drive(1'b1, 32'd20, 5'd5, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        fwd_rs1 = 5'd5;
        #1;
        chk("fwd_newest_hit", fwd_hit1, 1'b1);
        chk("fwd_newest_data", fwd_data1, 32'd20);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b1, 32'd7, 5'd0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        fwd_rs2 = 5'd0;
        #1;
        chk("fwd_r0_hit", fwd_hit2, 1'b0);
        chk("fwd_r0_data", fwd_data2, 32'd0);
        bus.wb_ready = 1'b1;
        cyc();
`endif

        // Randomized traffic against the FIFO model.
        for (int n = 0; n < 600; n++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.wb_ready = ($urandom_range(0, 2) != 0);
            bus.res_in   = $urandom;
            bus.ir_in    = $urandom;
            bus.pc_in    = 30'($urandom);
            bus.rd_in    = 5'($urandom_range(0, 7));
            bus.we_in    = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 31) == 0);
`ifdef WB_FWD_EN
            fwd_rs1 = 5'($urandom_range(0, 7));
            fwd_rs2 = 5'($urandom_range(0, 7));
`endif
            cyc();
        end
        flush = 1'b0;

        // Reset while holding two entries: outputs clear without waiting for a clock.
        drive(1'b1, 32'h1111, 5'd1, 1'b0);
        cyc();
        drive(1'b1, 32'h2222, 5'd2, 1'b0);
        cyc();
        chk("pre_reset_occ", occupancy, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_reset_occ", occupancy, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
